get_reg: RTL and testbench
==========================

# get_reg

Register-index-to-ABI-name lookup for the RISC-V disassembly/trace path. Accepts NUM_PORTS 5-bit integer register indices per cycle (rd, rs1, rs2 in the standard configuration) and returns each register's ABI mnemonic as a packed, right-justified ASCII string with its character count. Sits between the instruction field extractor and the trace formatter; outputs are registered.

## Interface
- NUM_PORTS, default 3: number of independent lookup lanes.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_PORTS  per-lane request strobe.
- in_idx  input  NUM_PORTS×5  per-lane register index x0..x31, lane i at bits [5i+4:5i].
- out_valid  output  NUM_PORTS  per-lane result strobe.
- out_name  output  NUM_PORTS×32  per-lane ASCII name, lane i at bits [32i+31:32i].
- out_len  output  NUM_PORTS×3  per-lane character count, 2..4.

## Operation
- Mapping: x0 zero, x1 ra, x2 sp, x3 gp, x4 tp, x5–x7 t0–t2, x8 s0, x9 s1, x10–x17 a0–a7, x18–x27 s2–s11, x28–x31 t3–t6.
- Encoding: one byte per character, last character in bits [7:0], earlier characters in successively higher bytes. Unused high bytes are 0x00.
- Example encodings: zero = 32'h7A65726F, ra = 32'h00007261, s10 = 32'h00733130, t0 = 32'h00007430.
- A 32-bit compare against a right-justified string literal therefore matches exactly.
- out_len values: 4 for zero, 3 for s10 and s11, 2 for all other names.
- Lanes are fully independent. Identical indices on several lanes in the same cycle are legal and each lane returns the same name.
- The lookup is total: every 5-bit index has a defined name, and no error output exists.

## Timing
- Latency is 1 cycle: in_valid/in_idx sampled at edge N produce out_valid/out_name/out_len after edge N.
- in_valid high: the lane's out_name and out_len load the new lookup, and out_valid goes 1.
- in_valid low: out_valid goes 0, and out_name and out_len hold their previous values.
- No back-pressure. A new request is accepted on every cycle per lane.
- rst_n low: every out_valid, out_name and out_len clears to 0 immediately, independent of clk.
  - This includes requests in flight.
  - The first request sampled after rst_n deasserts completes normally.

## Configuration
- GETREG_FP_ALIAS_EN defined: x8 returns "fp" (32'h00006670, len 2).
- GETREG_FP_ALIAS_EN undefined: x8 returns "s0" (32'h00007330, len 2).
- All other entries are unaffected by the macro.

## Structure
- Shared package getreg_pkg holds:
  - typedef reg_name_t (logic [31:0]) and typedef reg_len_t (logic [2:0]).
  - constant REG_IDX_W = 5.
  - the ABI-name constants.
  - a function returning {name, len} for an index.
- Sub-module get_reg_lut: purely combinational single-lane lookup (5-bit index in, name and length out), instantiated NUM_PORTS times via generate.
- The top level holds only the output registers.

## Test plan
- Sweep x0..x31 on lane 0, one per cycle with in_valid=1 -> each out_name and out_len matches the mapping one cycle later; x0 gives 32'h7A65726F, len 4.
- Lanes 0/1/2 given 10/11/12 in one cycle -> next cycle names a0/a1/a2 (32'h00006130/6131/6132), out_valid=3'b111.
- in_valid=3'b001 with idx 27 on lane 0, then in_valid=0 -> lane 0 shows s11 (32'h00733131, len 3) with out_valid=1, then out_valid=0 with the name held.
- Assert rst_n low mid-stream between clock edges -> all outputs 0 before the next edge; a request after release, idx 2, gives sp (32'h00007370).
- Build with and without GETREG_FP_ALIAS_EN, idx 8 -> 32'h00006670 vs 32'h00007330.
- All three lanes given idx 31 simultaneously -> every lane returns t6 (32'h00007436, len 2).

Source files
------------

// File: rtl/get_reg_pkg.sv
// getreg_pkg: shared types, ABI-name constants and the index->{name,len} lookup.
// Optional feature macro: GETREG_FP_ALIAS_EN (x8 reads "fp" instead of "s0").
package getreg_pkg;
  localparam int REG_IDX_W = 5;

  typedef logic [31:0] reg_name_t;
  typedef logic [2:0]  reg_len_t;

  typedef struct packed {
    reg_name_t name;
    reg_len_t  len;
  } reg_ent_t;

  // Right-justified ASCII, last character in the low byte
  localparam reg_name_t NAME_ZERO = 32'h7A65726F;
  localparam reg_name_t NAME_RA   = 32'h00007261;
  localparam reg_name_t NAME_SP   = 32'h00007370;
  localparam reg_name_t NAME_GP   = 32'h00006770;
  localparam reg_name_t NAME_TP   = 32'h00007470;
  localparam reg_name_t NAME_FP   = 32'h00006670;

  localparam logic [7:0] CH_A = 8'h61;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_T = 8'h74;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;

  // Letter plus one decimal digit, e.g. "a3"
  function automatic reg_name_t two_ch(input logic [7:0] c, input logic [7:0] n);
    return {16'h0000, c, CH_0 + n};
  endfunction

  // Total lookup: every 5-bit index maps to a name
  function automatic reg_ent_t reg_lookup(input logic [REG_IDX_W-1:0] idx);
    reg_ent_t   e;
    logic [7:0] i8;
    i8     = {3'b000, idx};
    e.name = NAME_ZERO;
    e.len  = 3'd2;
    if (idx == 5'd0) begin
      e.name = NAME_ZERO;
      e.len  = 3'd4;
    end
    else if (idx == 5'd1) e.name = NAME_RA;
    else if (idx == 5'd2) e.name = NAME_SP;
    else if (idx == 5'd3) e.name = NAME_GP;
    else if (idx == 5'd4) e.name = NAME_TP;
    else if (idx <= 5'd7) e.name = two_ch(CH_T, i8 - 8'd5);
    else if (idx == 5'd8) begin
`ifdef GETREG_FP_ALIAS_EN
      e.name = NAME_FP;
`else
      e.name = two_ch(CH_S, 8'd0);
`endif
    end
    else if (idx == 5'd9)  e.name = two_ch(CH_S, 8'd1);
    else if (idx <= 5'd17) e.name = two_ch(CH_A, i8 - 8'd10);
    else if (idx <= 5'd25) e.name = two_ch(CH_S, i8 - 8'd16);
    else if (idx <= 5'd27) begin
      // s10 / s11 are the only three-character names
      e.name = {8'h00, CH_S, CH_1, CH_0 + (i8 - 8'd26)};
      e.len  = 3'd3;
    end
    else e.name = two_ch(CH_T, i8 - 8'd25);
    return e;
  endfunction
endpackage

// File: rtl/get_reg_if.sv
// get_reg_if: request/result bundle for the register-name lookup lanes.
interface get_reg_if #(parameter int NUM_PORTS = 3);
  import getreg_pkg::*;

  logic      [NUM_PORTS-1:0]                in_valid;
  logic      [NUM_PORTS-1:0][REG_IDX_W-1:0] in_idx;
  logic      [NUM_PORTS-1:0]                out_valid;
  reg_name_t [NUM_PORTS-1:0]                out_name;
  reg_len_t  [NUM_PORTS-1:0]                out_len;

  modport master (output in_valid, in_idx, input out_valid, out_name, out_len);
  modport slave  (input in_valid, in_idx, output out_valid, out_name, out_len);
endinterface

// File: rtl/get_reg_lut.sv
// get_reg_lut: combinational single-lane index -> ABI name/length.
import getreg_pkg::*;

module get_reg_lut (
  input  logic [REG_IDX_W-1:0] idx,
  output reg_name_t            name,
  output reg_len_t             len
);
  reg_ent_t ent;

  // Pure table lookup via the shared package function
  always_comb begin
    ent  = reg_lookup(idx);
    name = ent.name;
    len  = ent.len;
  end
endmodule

// File: rtl/get_reg.sv
// get_reg: NUM_PORTS independent register-name lookups, one-cycle registered.
// Optional feature macro: GETREG_FP_ALIAS_EN (x8 reads "fp").
import getreg_pkg::*;

module get_reg #(
  parameter int NUM_PORTS = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  get_reg_if.slave bus
);
  reg_name_t [NUM_PORTS-1:0] lut_name;
  reg_len_t  [NUM_PORTS-1:0] lut_len;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    get_reg_lut u_lut (
      .idx  (bus.in_idx[g]),
      .name (lut_name[g]),
      .len  (lut_len[g])
    );
  end

  // Output registers: load on valid, otherwise hold data and drop valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= '0;
      bus.out_name  <= '0;
      bus.out_len   <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (bus.in_valid[i]) begin
          bus.out_name[i] <= lut_name[i];
          bus.out_len[i]  <= lut_len[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_get_reg.sv
// tb_get_reg: table vectors, index sweep, async reset and random lanes vs a string model.
module tb_get_reg;
  localparam int NP = 3;

`ifdef GETREG_FP_ALIAS_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  localparam logic [31:0] X8 = FP ? 32'h00006670 : 32'h00007330;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  get_reg_if #(.NUM_PORTS(NP)) bus ();

  get_reg #(.NUM_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state: what each lane should be showing
  logic [NP-1:0]       m_vld;
  logic [NP-1:0][31:0] m_name;
  logic [NP-1:0][2:0]  m_len;

  function automatic string abi(int i);
    string fix[5] = '{"zero", "ra", "sp", "gp", "tp"};
    if (i <= 4)  return fix[i];
    if (i <= 7)  return $sformatf("t%0d", i - 5);
    if (i == 8)  return FP ? "fp" : "s0";
    if (i == 9)  return "s1";
    if (i <= 17) return $sformatf("a%0d", i - 10);
    if (i <= 27) return $sformatf("s%0d", i - 16);
    return $sformatf("t%0d", i - 25);
  endfunction

  function automatic logic [31:0] pack_str(string s);
    logic [31:0] v = '0;
    for (int k = 0; k < s.len(); k++) v = {v[23:0], s[k]};
    return v;
  endfunction

  task automatic chk(string what, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Drive one cycle, advance past the edge, update the model
  task automatic apply(logic [NP-1:0] v, logic [NP-1:0][4:0] ix);
    bus.in_valid = v;
    bus.in_idx   = ix;
    @(posedge clk);
    #1;
    m_vld = v;
    for (int l = 0; l < NP; l++)
      if (v[l]) begin
        m_name[l] = pack_str(abi(int'(ix[l])));
        m_len[l]  = 3'(abi(int'(ix[l])).len());
      end
  endtask

  task automatic chk_model(string tag);
    for (int l = 0; l < NP; l++) begin
      chk($sformatf("%s vld%0d", tag, l), 32'(bus.out_valid[l]), 32'(m_vld[l]));
      chk($sformatf("%s name%0d", tag, l), bus.out_name[l], m_name[l]);
      chk($sformatf("%s len%0d", tag, l), 32'(bus.out_len[l]), 32'(m_len[l]));
    end
  endtask

  typedef struct {
    logic [NP-1:0]       vld;
    logic [NP-1:0][4:0]  idx;
    logic [NP-1:0]       exp_vld;
    logic [NP-1:0][31:0] exp_name;
    logic [NP-1:0][2:0]  exp_len;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{3'b111, {5'd12, 5'd11, 5'd10}, 3'b111,
               {32'h00006132, 32'h00006131, 32'h00006130}, {3'd2, 3'd2, 3'd2}};
    tbl[1] = '{3'b001, {5'd0, 5'd0, 5'd27}, 3'b001,
               {32'h00006132, 32'h00006131, 32'h00733131}, {3'd2, 3'd2, 3'd3}};
    tbl[2] = '{3'b000, {5'd3, 5'd3, 5'd3}, 3'b000,
               {32'h00006132, 32'h00006131, 32'h00733131}, {3'd2, 3'd2, 3'd3}};
    tbl[3] = '{3'b111, {5'd31, 5'd31, 5'd31}, 3'b111,
               {32'h00007436, 32'h00007436, 32'h00007436}, {3'd2, 3'd2, 3'd2}};
    tbl[4] = '{3'b111, {5'd26, 5'd8, 5'd0}, 3'b111,
               {32'h00733130, X8, 32'h7A65726F}, {3'd3, 3'd2, 3'd4}};
    tbl[5] = '{3'b010, {5'd2, 5'd1, 5'd2}, 3'b010,
               {32'h00733130, 32'h00007261, 32'h7A65726F}, {3'd3, 3'd2, 3'd4}};

    m_vld = '0; m_name = '0; m_len = '0;
    bus.in_valid = '0;
    bus.in_idx   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset out_name",  32'(bus.out_name[0] | bus.out_name[1] | bus.out_name[2]), 32'h0);
    chk("reset out_len",   32'({bus.out_len}), 32'h0);
    rst_n = 1'b1;

    // Directed table with literal expectations
    for (int t = 0; t < 6; t++) begin
      apply(tbl[t].vld, tbl[t].idx);
      chk($sformatf("tbl%0d valid", t), 32'(bus.out_valid), 32'(tbl[t].exp_vld));
      for (int l = 0; l < NP; l++) begin
        chk($sformatf("tbl%0d name%0d", t, l), bus.out_name[l], tbl[t].exp_name[l]);
        chk($sformatf("tbl%0d len%0d", t, l), 32'(bus.out_len[l]), 32'(tbl[t].exp_len[l]));
      end
    end

    // Sweep every index on lane 0
    for (int i = 0; i < 32; i++) begin
      apply(3'b001, {5'd0, 5'd0, 5'(i)});
      chk($sformatf("sweep x%0d name", i), bus.out_name[0], pack_str(abi(i)));
      chk($sformatf("sweep x%0d len", i), 32'(bus.out_len[0]), 32'(abi(i).len()));
      chk($sformatf("sweep x%0d vld", i), 32'(bus.out_valid), 32'h1);
    end

    // Async reset between edges, with a request in flight
    apply(3'b111, {5'd20, 5'd26, 5'd0});
    bus.in_valid = 3'b111;
    bus.in_idx   = {5'd5, 5'd6, 5'd7};
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(bus.out_valid), 32'h0);
    chk("async rst name0", bus.out_name[0], 32'h0);
    chk("async rst name2", bus.out_name[2], 32'h0);
    chk("async rst len",   32'({bus.out_len}), 32'h0);
    @(posedge clk);
    #1;
    chk("held rst valid", 32'(bus.out_valid), 32'h0);
    chk("held rst name1", bus.out_name[1], 32'h0);
    rst_n = 1'b1;
    m_vld = '0; m_name = '0; m_len = '0;
    apply(3'b001, {5'd0, 5'd0, 5'd2});
    chk("post rst sp name", bus.out_name[0], 32'h00007370);
    chk("post rst sp len",  32'(bus.out_len[0]), 32'd2);
    chk("post rst valid",   32'(bus.out_valid), 32'h1);
    chk_model("post rst");

    // Random lanes against the model
    for (int n = 0; n < 300; n++) begin
      logic [NP-1:0][4:0] ix;
      for (int l = 0; l < NP; l++) ix[l] = 5'($urandom_range(0, 31));
      apply(3'($urandom), ix);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
